// File: rtl/dec4_16_stream.sv
// 4-to-16 decoder feeding a 2-entry valid/ready FIFO.
// Define DEC4_16_STATS_EN to add the saturating xfer_cnt output.
module dec4_16_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Y,
    input  logic        GATE,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] X,
    output logic        out_valid,
    input  logic        out_ready
`ifdef DEC4_16_STATS_EN
    ,
    output logic [7:0]  xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] head;
    logic [15:0] tail;
    logic        rdy_q;
    logic        vld_q;
    logic [15:0] dec;
    logic        push;
    logic        pop;

    always_comb begin
        dec = 16'h0000;
        if (GATE) begin
            dec = 16'h0001 << Y;
        end
    end

    assign push      = in_valid & rdy_q;
    assign pop       = vld_q & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    // head is cleared whenever the FIFO empties, so X reads 0 when idle
    assign X         = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= 16'h0000;
            tail  <= 16'h0000;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= dec;
                        state <= ONE;
                        vld_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= dec;
                    end else if (push) begin
                        tail  <= dec;
                        state <= FULL;
                        rdy_q <= 1'b0;
                    end else if (pop) begin
                        head  <= 16'h0000;
                        state <= EMPTY;
                        vld_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head  <= tail;
                        tail  <= 16'h0000;
                        state <= ONE;
                        rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    head  <= 16'h0000;
                    tail  <= 16'h0000;
                    rdy_q <= 1'b1;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEC4_16_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= 8'd0;
        end else if (pop && xfer_cnt != 8'hff) begin
            xfer_cnt <= xfer_cnt + 8'd1;
        end
    end
`endif

endmodule
